image_ram_writer: RTL and testbench

Streams processed 24-bit RGB pixels into the single-port `ram` block RAM image buffer, one pixel per accepted handshake, at sequential addresses from 0. It is the write-side counterpart to the sequential RAM reader. It sits between a pixel-processing stage (valid/ready source) and port A of `ram`. It signals frame completion or a short frame to the controlling logic.

---
 rtl/image_ram_pkg.sv | 19 +
 rtl/pix_checksum.sv | 23 ++
 rtl/image_ram_writer.sv | 126 ++++++++++++
 tb/tb_image_ram_writer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_ram_pkg.sv
// Shared image-buffer constants and writer FSM encoding, used by the RAM writer and reader.
package image_ram_pkg;

  localparam int IMG_ADDR_W     = 16;
  localparam int IMG_DATA_W     = 24;
  localparam int IMG_NUM_PIXELS = 41750;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FINISH = 2'd2
  } wr_state_e;

  // Count value held while the final pixel of a full frame is being accepted.
  function automatic int last_pixel_count(input int num_pixels);
    return num_pixels - 1;
  endfunction

endpackage

// File: rtl/pix_checksum.sv
// Modulo-2^W running sum of accepted pixels; zero latency, clear wins over enable.
module pix_checksum #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/image_ram_writer.sv
// Streams pixels into RAM port A at sequential addresses, one per handshake; write issued 1 cycle after accept.
// s_ready depends on state only. Optional IMG_WR_CHECKSUM_EN adds a per-frame pixel checksum output.
module image_ram_writer
  import image_ram_pkg::*;
#(
  parameter int ADDR_W     = IMG_ADDR_W,
  parameter int DATA_W     = IMG_DATA_W,
  parameter int NUM_PIXELS = IMG_NUM_PIXELS
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              ena,
  output logic [0:0]        wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              busy,
  output logic              done,
  output logic              short_err,
  output logic [ADDR_W:0]   px_count
`ifdef IMG_WR_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(last_pixel_count(NUM_PIXELS));
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  wr_state_e state_q;
  wr_state_e state_d;
  logic      arm;
  logic      accept;
  logic      frame_full;

  // px_count doubles as the next write address: it never exceeds NUM_PIXELS-1 while accepting.
  assign accept     = (state_q == WRITE) && s_valid;
  assign frame_full = (px_count == LAST_CNT);

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    arm     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          arm     = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid && (frame_full || s_last)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      ena   <= 1'b0;
      wea   <= 1'b0;
      addra <= '0;
      dina  <= '0;
    end else begin
      ena <= accept;
      wea <= accept;
      if (accept) begin
        addra <= px_count[ADDR_W-1:0];
        dina  <= s_data;
      end
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      px_count  <= '0;
      short_err <= 1'b0;
    end else if (arm) begin
      px_count  <= '0;
      short_err <= 1'b0;
    end else if (accept) begin
      px_count <= px_count + CNT_ONE;
      // s_last on the final pixel of a full frame is a normal end.
      if (s_last && !frame_full) begin
        short_err <= 1'b1;
      end
    end
  end

`ifdef IMG_WR_CHECKSUM_EN
  pix_checksum #(
    .W(DATA_W)
  ) u_checksum (
    .clk (clka),
    .rst (rst),
    .clr (arm),
    .en  (accept),
    .din (s_data),
    .sum (checksum)
  );
`endif

endmodule

// File: tb/tb_image_ram_writer.sv
// Bench for image_ram_writer: frame-level reference model, per-cycle compare, directed and random frames.
module tb_image_ram_writer;

  localparam int NPIX = 8;
  localparam int BIG  = 41750;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [23:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready, ena, busy, done, short_err;
  logic [0:0]  wea;
  logic [15:0] addra;
  logic [23:0] dina;
  logic [16:0] px_count;

  logic        b_start = 1'b0;
  logic        b_valid = 1'b0;
  logic [23:0] b_data = '0;
  logic        b_s_ready, b_ena, b_busy, b_done, b_short_err;
  logic [0:0]  b_wea;
  logic [15:0] b_addra;
  logic [23:0] b_dina;
  logic [16:0] b_px_count;
`ifdef IMG_WR_CHECKSUM_EN
  logic [23:0] checksum, b_checksum;
`endif

  always #5 clk = ~clk;

  image_ram_writer #(.ADDR_W(16), .DATA_W(24), .NUM_PIXELS(NPIX)) dut (
    .clka(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .busy(busy),
    .done(done), .short_err(short_err), .px_count(px_count)
`ifdef IMG_WR_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  image_ram_writer #(.ADDR_W(16), .DATA_W(24), .NUM_PIXELS(BIG)) dut_big (
    .clka(clk), .rst(rst), .start(b_start), .s_valid(b_valid), .s_data(b_data), .s_last(1'b0),
    .s_ready(b_s_ready), .ena(b_ena), .wea(b_wea), .addra(b_addra), .dina(b_dina), .busy(b_busy),
    .done(b_done), .short_err(b_short_err), .px_count(b_px_count)
`ifdef IMG_WR_CHECKSUM_EN
    , .checksum(b_checksum)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level view of the writer (active frame, one-cycle finish, pixel list).
  bit          m_active, m_fin, m_short, e_wr;
  int          m_n, e_addr;
  logic [23:0] e_din, m_sum;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_fin = 0; m_short = 0; m_n = 0;
      e_wr = 0; e_addr = 0; e_din = '0; m_sum = '0;
    end else begin
      cyc++;
      e_wr = 0;
      if (m_fin) begin
        m_fin = 0;
      end else if (m_active) begin
        if (s_valid) begin
          e_wr = 1; e_addr = m_n; e_din = s_data;
          m_sum = m_sum + s_data;
          m_n++;
          if (m_n == NPIX) begin
            m_active = 0; m_fin = 1;
          end else if (s_last) begin
            m_active = 0; m_fin = 1; m_short = 1;
          end
        end
      end else if (start) begin
        m_active = 1; m_n = 0; m_short = 0; m_sum = '0;
      end
    end
  end

  bit chk_on = 0;
  int wr_addr_log[$];
  int wr_data_log[$];
  int done_cnt = 0;
  int done_cyc = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("s_ready", s_ready, m_active);
      chk("busy", busy, m_active || m_fin);
      chk("done", done, m_fin);
      chk("ena", ena, e_wr);
      chk("wea", wea, e_wr);
      chk("addra", addra, e_addr);
      chk("dina", dina, e_din);
      chk("short_err", short_err, m_short);
      chk("px_count", px_count, m_n);
`ifdef IMG_WR_CHECKSUM_EN
      chk("checksum", checksum, m_sum);
`endif
      if (wea[0]) begin
        wr_addr_log.push_back(int'(addra));
        wr_data_log.push_back(int'(dina));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic drive(input bit st, input bit v, input logic [23:0] d, input bit l);
    @(negedge clk);
    #1;
    start = st; s_valid = v; s_data = d; s_last = l;
  endtask

  task automatic clear_logs();
    wr_addr_log.delete();
    wr_data_log.delete();
    done_cnt = 0;
  endtask

  task automatic check_seq_writes(input string tag, input int n);
    chk({tag, "_nwrites"}, wr_addr_log.size(), n);
    for (int i = 0; i < n && i < wr_addr_log.size(); i++) begin
      chk({tag, "_addr"}, wr_addr_log[i], i);
    end
  endtask

  int t0;
  int nacc;
  int bidx;
  int blast;
  bit bgot;
  logic [23:0] bsum;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_wea", wea, 0);
    chk("rst_addra", addra, 0);
    chk("rst_px_count", px_count, 0);
    chk("rst_busy", busy, 0);
    #1 rst = 1'b0;
    chk_on = 1;
    drive(0, 0, 0, 0);

    // Full frame, valid held high, data = addr+1.
    clear_logs();
    drive(1, 0, 0, 0);
    t0 = cyc;
    for (int k = 0; k < NPIX; k++) drive(0, 1, 24'(k + 1), 0);
    repeat (3) drive(0, 0, 0, 0);
    check_seq_writes("full", 8);
    for (int i = 0; i < 8 && i < wr_data_log.size(); i++) chk("full_data", wr_data_log[i], i + 1);
    chk("full_done_cnt", done_cnt, 1);
    // done occupies the 10th cycle when the start cycle is counted as the first.
    chk("full_done_lat", done_cyc - t0, 9);
    chk("full_px_count", px_count, 8);
    chk("full_short", short_err, 0);
`ifdef IMG_WR_CHECKSUM_EN
    chk("full_checksum", checksum, 36);
`endif

    // Valid toggled every other cycle.
    clear_logs();
    drive(1, 0, 0, 0);
    t0 = cyc;
    nacc = 0;
    for (int i = 0; i < 16; i++) begin
      drive(0, (i % 2) == 0, 24'(nacc + 1), 0);
      if (i % 2 == 0) nacc++;
    end
    repeat (3) drive(0, 0, 0, 0);
    check_seq_writes("toggle", 8);
    chk("toggle_done_cnt", done_cnt, 1);
    chk("toggle_done_lat", done_cyc - t0, 16);

    // s_last on pixel 5, then more pixels offered after the frame ends.
    clear_logs();
    drive(1, 0, 0, 0);
    for (int k = 0; k < 10; k++) drive(0, 1, 24'($urandom), k == 4);
    drive(0, 0, 0, 0);
    check_seq_writes("short", 5);
    chk("short_err", short_err, 1);
    chk("short_done_cnt", done_cnt, 1);
    chk("short_px_count", px_count, 5);

    // s_last exactly on the final pixel is a normal frame.
    clear_logs();
    drive(1, 0, 0, 0);
    for (int k = 0; k < NPIX; k++) drive(0, 1, 24'($urandom), k == NPIX - 1);
    repeat (2) drive(0, 0, 0, 0);
    chk("lastok_short", short_err, 0);
    chk("lastok_px_count", px_count, 8);

    // start mid-frame and pixels after FINISH are ignored.
    clear_logs();
    drive(1, 0, 0, 0);
    for (int k = 0; k < 14; k++) drive(k == 3, 1, 24'($urandom), 0);
    drive(0, 0, 0, 0);
    check_seq_writes("midstart", 8);
    chk("midstart_done_cnt", done_cnt, 1);

    // Reset after three accepts.
    clear_logs();
    drive(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive(0, 1, 24'(k + 7), 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_wea", wea, 0);
    chk("arst_ena", ena, 0);
    chk("arst_addra", addra, 0);
    chk("arst_dina", dina, 0);
    chk("arst_s_ready", s_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_px_count", px_count, 0);
    clear_logs();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) drive(0, 1, 24'($urandom), 0);
    chk("arst_no_writes", wr_addr_log.size(), 0);
    drive(0, 0, 0, 0);

    // Random traffic with occasional resets; the per-cycle compare does the checking.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 6) == 0, ($urandom % 10) < 6, 24'($urandom), ($urandom % 12) == 0);
      if (($urandom % 300) == 0) begin
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
      end
    end
    repeat (3) drive(0, 0, 0, 0);

    // Full-size frame on the second instance.
    @(negedge clk);
    #1 b_start = 1'b1; b_valid = 1'b1; b_data = '0;
    bidx = 0; blast = -1; bgot = 0; bsum = '0;
    for (int j = 0; j < BIG + 10; j++) begin
      @(negedge clk);
      if (b_wea[0]) begin
        chk("big_addra", b_addra, bidx);
        chk("big_dina", b_dina, bidx);
        chk("big_ena", b_ena, 1);
        bsum = bsum + 24'(bidx);
        blast = int'(b_addra);
        bidx++;
      end
      if (b_done) begin
        bgot = 1;
        break;
      end
      #1 b_start = 1'b0; b_data = 24'(j);
    end
    #1 b_valid = 1'b0;
    chk("big_done_seen", bgot, 1);
    chk("big_nwrites", bidx, BIG);
    chk("big_last_addr", blast, BIG - 1);
    chk("big_px_count", b_px_count, BIG);
    chk("big_short", b_short_err, 0);
    chk("big_busy_in_finish", b_busy, 1);
    chk("big_ready_in_finish", b_s_ready, 0);
`ifdef IMG_WR_CHECKSUM_EN
    chk("big_checksum", b_checksum, bsum);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
